frame_scheduler: RTL

Per-frame sequencer for the triangle pipeline. Detects the start of vertical blanking from the pixel counters and advances the rotation angle once per frame. It then waits for the vertex shader to settle and latches the transformed vertices into shadow registers. The rasterizer therefore sees geometry that is constant across the whole active region. It sits between `signal_480p60` and `vertex_shader` on one side and `rasterizer` on the other, all in the `clk_pix` domain.

---
 rtl/frame_sched_pkg.sv | 41 ++++
 rtl/angle_accum.sv | 32 +++
 rtl/frame_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/frame_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | frame_sched_pkg : shared types and constants for frame_scheduler   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package frame_sched_pkg;

  localparam int ANGLE_MAX        = 360;
  localparam int ANGLE_W          = 9;
  localparam int COORD_W          = 10;
  localparam int V_ACTIVE_DEFAULT = 480;

  localparam logic [ANGLE_W:0] ANGLE_MAX_W = (ANGLE_W+1)'(ANGLE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADVANCE = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_LATCH   = 2'd3
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] ax;
    logic [COORD_W-1:0] ay;
    logic [COORD_W-1:0] bx;
    logic [COORD_W-1:0] by;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
  } tri_t;

  // Both operands are below 360, so a single conditional subtract suffices.
  function automatic logic [ANGLE_W-1:0] angle_wrap(input logic [ANGLE_W-1:0] a,
                                                    input logic [ANGLE_W-1:0] step);
    logic [ANGLE_W:0] s;
    s = {1'b0, a} + {1'b0, step};
    if (s >= ANGLE_MAX_W) s = s - ANGLE_MAX_W;
    return s[ANGLE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/angle_accum.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | angle_accum : registered mod-360 accumulator with enable           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module angle_accum
  import frame_sched_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [ANGLE_W-1:0] step_i,
  output logic [ANGLE_W-1:0] angle_o
);

  logic [ANGLE_W-1:0] angle_q;
  logic [ANGLE_W-1:0] angle_d;

  always_comb begin
    angle_d = angle_q;
    if (en_i) angle_d = angle_wrap(angle_q, step_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) angle_q <= '0;
    else       angle_q <= angle_d;
  end

  assign angle_o = angle_q;

endmodule
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | frame_scheduler : per-frame angle advance and vertex shadow latch  |
// | Optional FRAME_SCHED_STATS_EN adds the frame_count output.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int ANGLE_STEP = 1,
  parameter int VS_LATENCY = 2,
  parameter int V_ACTIVE   = V_ACTIVE_DEFAULT
) (
  input  logic               clk_pix,
  input  logic               reset,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               pause,
  input  logic [COORD_W-1:0] vax,
  input  logic [COORD_W-1:0] vay,
  input  logic [COORD_W-1:0] vbx,
  input  logic [COORD_W-1:0] vby,
  input  logic [COORD_W-1:0] vcx,
  input  logic [COORD_W-1:0] vcy,
  output logic [ANGLE_W-1:0] angle,
  output logic [COORD_W-1:0] ax,
  output logic [COORD_W-1:0] ay,
  output logic [COORD_W-1:0] bx,
  output logic [COORD_W-1:0] by,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               busy,
  output logic               frame_done
`ifdef FRAME_SCHED_STATS_EN
  ,
  output logic [15:0]        frame_count
`endif
);

  localparam logic [COORD_W-1:0] TRIG_ROW    = COORD_W'(V_ACTIVE);
  localparam logic [3:0]         SETTLE_LAST = 4'(VS_LATENCY - 1);
  localparam logic [ANGLE_W-1:0] STEP        = ANGLE_W'(ANGLE_STEP);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] settle_cnt_q;
  logic [3:0] settle_cnt_d;
  logic       pause_q;
  logic       pause_d;
  tri_t       shadow_q;
  logic       frame_done_q;
  logic       trigger;
  logic       advance_en;
  logic       latch_en;
  tri_t       live;

  assign trigger = (x == '0) && (y == TRIG_ROW);
  assign live    = '{ax: vax, ay: vay, bx: vbx, by: vby, cx: vcx, cy: vcy};

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      pause_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      pause_q      <= pause_d;
    end
  end

  // Triggers outside IDLE are dropped; pause is only captured with an accepted trigger.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    pause_d      = pause_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          pause_d = pause;
          state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        settle_cnt_d = '0;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = ST_LATCH;
        else                             settle_cnt_d = settle_cnt_q + 4'd1;
      end
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    advance_en = (state_q == ST_ADVANCE) && !pause_q;
    latch_en   = (state_q == ST_LATCH);
  end

  angle_accum u_angle_accum (
    .clk_i   (clk_pix),
    .rst_i   (reset),
    .en_i    (advance_en),
    .step_i  (STEP),
    .angle_o (angle)
  );

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      shadow_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= latch_en;
      if (latch_en) shadow_q <= live;
    end
  end

  assign ax         = shadow_q.ax;
  assign ay         = shadow_q.ay;
  assign bx         = shadow_q.bx;
  assign by         = shadow_q.by;
  assign cx         = shadow_q.cx;
  assign cy         = shadow_q.cy;
  assign frame_done = frame_done_q;

`ifdef FRAME_SCHED_STATS_EN
  logic [15:0] frame_count_q;

  always_ff @(posedge clk_pix) begin
    if (reset)         frame_count_q <= '0;
    else if (latch_en) frame_count_q <= frame_count_q + 16'd1;
  end

  assign frame_count = frame_count_q;
`endif

endmodule
`default_nettype wire
